// File: rtl/go_done_monitor.sv
// go_done_monitor: supervisor for the go/kill delay chain.
// Measures start-to-done latency, counts dones, sequences kill_clr.
module go_done_monitor #(
  parameter int CW          = 16,
  parameter int NW          = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CLR_HOLD    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          done_in,
  input  logic          kill_ltchd,
  input  logic          ack_clr,
  output logic          kill_clr,
  output logic          busy,
  output logic [CW-1:0] lat_cnt,
  output logic          lat_valid,
  output logic [NW-1:0] done_count,
  output logic          timeout,
  output logic          stray_done
);

  localparam int HW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_KILLED,
    S_TOUT,
    S_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] lat_q, lat_d;
  logic          lv_q, lv_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;
  logic          stray_q, stray_d;
  logic          kclr_q, kclr_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    lat_d   = lat_q;
    lv_d    = 1'b0;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    stray_d = stray_q;
    unique case (state_q)
      S_IDLE: begin
        if (done_in) stray_d = 1'b1;
        if (kill_ltchd) begin
          state_d = S_KILLED;
        end else if (start) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (kill_ltchd) begin
          state_d = S_KILLED;
        end else if (done_in) begin
          lat_d = timer_q + 1'b1;
          lv_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (start) timer_d = '0;
          else       state_d = S_IDLE;
        end else if (timer_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = S_TOUT;
          tout_d  = 1'b1;
        end
      end
      S_KILLED, S_TOUT: begin
        if (ack_clr) begin
          state_d = S_CLEAR;
          hold_d  = '0;
          tout_d  = 1'b0;
          stray_d = 1'b0;
        end
      end
      S_CLEAR: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(CLR_HOLD - 1)) begin
          hold_d  = '0;
          // kill still latched means the chain re-killed during the clear
          state_d = kill_ltchd ? S_KILLED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    kclr_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      lat_q   <= '0;
      lv_q    <= 1'b0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      stray_q <= 1'b0;
      kclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      lat_q   <= lat_d;
      lv_q    <= lv_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      stray_q <= stray_d;
      kclr_q  <= kclr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign kill_clr   = kclr_q;
  assign lat_cnt    = lat_q;
  assign lat_valid  = lv_q;
  assign done_count = cnt_q;
  assign timeout    = tout_q;
  assign stray_done = stray_q;

endmodule

// File: tb/tb_go_done_monitor.sv
// tb_go_done_monitor: directed scenarios plus random run
// against a phase/age reference model.
module tb_go_done_monitor;

  localparam int CW = 16;
  localparam int NW = 8;
  localparam int TO = 8;
  localparam int CH = 2;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          done_in;
  logic          kill_ltchd;
  logic          ack_clr;
  logic          kill_clr;
  logic          busy;
  logic [CW-1:0] lat_cnt;
  logic          lat_valid;
  logic [NW-1:0] done_count;
  logic          timeout;
  logic          stray_done;

  int checks;
  int failures;

  go_done_monitor #(
    .CW(CW), .NW(NW), .TIMEOUT_CYC(TO), .CLR_HOLD(CH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .done_in(done_in),
    .kill_ltchd(kill_ltchd),
    .ack_clr(ack_clr),
    .kill_clr(kill_clr),
    .busy(busy),
    .lat_cnt(lat_cnt),
    .lat_valid(lat_valid),
    .done_count(done_count),
    .timeout(timeout),
    .stray_done(stray_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic s, input logic d,
                      input logic k, input logic a);
    start = s; done_in = d; kill_ltchd = k; ack_clr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  function automatic logic [28:0] outs();
    return {busy, kill_clr, lat_valid, timeout,
            stray_done, done_count, lat_cnt};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 29'd0) begin
      failures++;
      $display("FAIL reset_init outs=%h want 0", outs());
    end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy busy=%b want 1", busy);
    end
    do_reset();
    checks++;
    if (outs() !== 29'd0) begin
      failures++;
      $display("FAIL reset_mid outs=%h want 0", outs());
    end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'd4 || done_count !== 8'd1) begin
      failures++;
      $display("FAIL reset_remeasure lat=%0d cnt=%0d want 4 1",
               lat_cnt, done_count);
    end
  endtask

  task automatic test_latency();
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'd5 || lat_valid !== 1'b1 ||
        done_count !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL latency5 lat=%0d lv=%b cnt=%0d busy=%b want 5 1 1 0",
               lat_cnt, lat_valid, done_count, busy);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (lat_valid !== 1'b0 || lat_cnt !== 16'd5) begin
      failures++;
      $display("FAIL lv_pulse lv=%b lat=%0d want 0 5",
               lat_valid, lat_cnt);
    end
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'd1 || done_count !== 8'd2) begin
      failures++;
      $display("FAIL latency1 lat=%0d cnt=%0d want 1 2",
               lat_cnt, done_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) tick(0, 0, 0, 0);
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_early timeout=%b busy=%b want 0 1",
               timeout, busy);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_set timeout=%b want 1", timeout);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if (kill_clr !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_clr1 kill_clr=%b timeout=%b want 1 0",
               kill_clr, timeout);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (kill_clr !== 1'b1) begin
      failures++;
      $display("FAIL to_clr2 kill_clr=%b want 1", kill_clr);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (kill_clr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_exit kill_clr=%b busy=%b want 0 0",
               kill_clr, busy);
    end
    tick(1, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'(TO) || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_at_limit lat=%0d to=%b busy=%b want %0d 0 0",
               lat_cnt, timeout, busy, TO);
    end
  endtask

  task automatic test_kill_vs_done();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 0);
    checks++;
    if (busy !== 1'b1 || done_count !== 8'd0 || lat_valid !== 1'b0) begin
      failures++;
      $display("FAIL kill_done busy=%b cnt=%0d lv=%b want 1 0 0",
               busy, done_count, lat_valid);
    end
    tick(0, 0, 1, 1);
    checks++;
    if (kill_clr !== 1'b1) begin
      failures++;
      $display("FAIL kill_clr kill_clr=%b want 1", kill_clr);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || kill_clr !== 1'b0) begin
      failures++;
      $display("FAIL kill_exit busy=%b kill_clr=%b want 0 0",
               busy, kill_clr);
    end
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    checks++;
    if (busy !== 1'b1 || kill_clr !== 1'b0) begin
      failures++;
      $display("FAIL kill_reenter busy=%b kill_clr=%b want 1 0",
               busy, kill_clr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'd3 || done_count !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first lat=%0d cnt=%0d busy=%b want 3 1 1",
               lat_cnt, done_count, busy);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (lat_cnt !== 16'd3 || done_count !== 8'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second lat=%0d cnt=%0d busy=%b want 3 2 0",
               lat_cnt, done_count, busy);
    end
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 255; i++) tick(1, 1, 0, 0);
    checks++;
    if (done_count !== 8'd255) begin
      failures++;
      $display("FAIL wrap_255 cnt=%0d want 255", done_count);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (done_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_0 cnt=%0d busy=%b want 0 0",
               done_count, busy);
    end
  endtask

  task automatic test_stray();
    do_reset();
    tick(0, 1, 0, 0);
    checks++;
    if (stray_done !== 1'b1 || done_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_set st=%b cnt=%0d busy=%b want 1 0 0",
               stray_done, done_count, busy);
    end
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (stray_done !== 1'b1) begin
      failures++;
      $display("FAIL stray_sticky st=%b want 1", stray_done);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (stray_done !== 1'b0 || kill_clr !== 1'b1) begin
      failures++;
      $display("FAIL stray_clr st=%b kill_clr=%b want 0 1",
               stray_done, kill_clr);
    end
  endtask

  // reference: phase 0 idle, 1 measuring, 2 parked awaiting ack, 3 clearing
  int   ph, age, left, m_lat, m_cnt;
  logic m_lv, m_to, m_st;

  function automatic void model_step(logic s, logic d,
                                     logic k, logic a);
    m_lv = 1'b0;
    case (ph)
      0: begin
        if (d) m_st = 1'b1;
        if (k) ph = 2;
        else if (s) begin ph = 1; age = 0; end
      end
      1: begin
        age = age + 1;
        if (k) ph = 2;
        else if (d) begin
          m_lat = age;
          m_lv  = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << NW);
          if (s) age = 0;
          else   ph = 0;
        end else if (age == TO) begin
          m_to = 1'b1;
          ph   = 2;
        end
      end
      2: begin
        if (a) begin
          ph = 3; left = CH; m_to = 1'b0; m_st = 1'b0;
        end
      end
      default: begin
        left = left - 1;
        if (left == 0) ph = k ? 2 : 0;
      end
    endcase
  endfunction

  task automatic test_random();
    logic [28:0] exp;
    logic s, d, k, a;
    do_reset();
    ph = 0; age = 0; left = 0; m_lat = 0; m_cnt = 0;
    m_lv = 0; m_to = 0; m_st = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(99) < 35);
      d = ($urandom_range(99) < 20);
      k = ($urandom_range(99) < 6);
      a = ($urandom_range(99) < 25);
      model_step(s, d, k, a);
      tick(s, d, k, a);
      exp = {ph != 0, ph == 3, m_lv, m_to, m_st,
             NW'(m_cnt), CW'(m_lat)};
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, outs(), exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    start = 0; done_in = 0; kill_ltchd = 0; ack_clr = 0;
    test_reset();
    test_latency();
    test_timeout();
    test_kill_vs_done();
    test_back_to_back();
    test_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
